// File: rtl/amba_axi4_monitor_pkg.sv
// Shared types for the AXI4 burst monitor: violation codes, widths and the
// priority helper that picks the reported code out of a violation vector.
package amba_axi4_monitor_pkg;

  localparam int ERR_COUNT = 11;
  localparam int LEN_WIDTH = 8;
  localparam int NUM_CH    = 5;

  typedef enum logic [3:0] {
    ERR_NONE          = 4'd0,
    ERR_AW_VALID_DROP = 4'd1,
    ERR_AW_PAYLOAD    = 4'd2,
    ERR_W_VALID_DROP  = 4'd3,
    ERR_W_NO_AW       = 4'd4,
    ERR_WLAST_EARLY   = 4'd5,
    ERR_WLAST_MISSING = 4'd6,
    ERR_B_UNEXPECTED  = 4'd7,
    ERR_AR_VALID_DROP = 4'd8,
    ERR_R_UNEXPECTED  = 4'd9,
    ERR_OVERFLOW      = 4'd10,
    ERR_TIMEOUT       = 4'd11
  } err_code_t;

  // Bit i of the vector stands for code i+1; the lowest code wins.
  function automatic err_code_t first_err(input logic [ERR_COUNT-1:0] e);
    err_code_t r;
    r = ERR_NONE;
    for (int i = ERR_COUNT - 1; i >= 0; i--)
      if (e[i]) r = err_code_t'(4'(i + 1));
    return r;
  endfunction

endpackage

// File: rtl/amba_axi4_len_fifo.sv
// Small synchronous FIFO holding AWLEN of accepted write bursts until their
// last W beat. Push while full is accepted only when a pop frees a slot.
module amba_axi4_len_fifo
  import amba_axi4_monitor_pkg::*;
#(
  parameter int WIDTH = LEN_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [PW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge ACLK) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/amba_axi4_burst_monitor.sv
// Passive AXI4 burst monitor: burst length tracking, outstanding counts,
// VALID/payload stability and per-channel stall timeouts.
module amba_axi4_burst_monitor
  import amba_axi4_monitor_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int MAXWAIT         = 16
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic                                   AWVALID,
  input  logic                                   AWREADY,
  input  logic [ADDRESS_WIDTH-1:0]               AWADDR,
  input  logic [7:0]                             AWLEN,
  input  logic                                   WVALID,
  input  logic                                   WREADY,
  input  logic                                   WLAST,
  input  logic                                   BVALID,
  input  logic                                   BREADY,
  input  logic                                   ARVALID,
  input  logic                                   ARREADY,
  input  logic [ADDRESS_WIDTH-1:0]               ARADDR,
  input  logic [7:0]                             ARLEN,
  input  logic                                   RVALID,
  input  logic                                   RREADY,
  input  logic                                   RLAST,
  output logic                                   err_valid,
  output logic [3:0]                             err_code,
  output logic [ERR_COUNT-1:0]                   err_sticky,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   wr_outstanding,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   rd_outstanding
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(MAXWAIT + 1);
  localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] MAXW    = SW'(MAXWAIT);

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign b_hs  = BVALID & BREADY;
  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID & RREADY;

  // AR payload is carried on the port list but no AR payload check exists.
  logic unused_ar;
  assign unused_ar = ^{ARADDR, ARLEN};

  // Previous-cycle channel state for the stability checks.
  logic                     awv_q, awr_q, wv_q, wr_q, arv_q, arr_q;
  logic [ADDRESS_WIDTH-1:0] awaddr_q;
  logic [7:0]               awlen_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awv_q    <= 1'b0;
      awr_q    <= 1'b0;
      wv_q     <= 1'b0;
      wr_q     <= 1'b0;
      arv_q    <= 1'b0;
      arr_q    <= 1'b0;
      awaddr_q <= '0;
      awlen_q  <= '0;
    end else begin
      awv_q    <= AWVALID;
      awr_q    <= AWREADY;
      wv_q     <= WVALID;
      wr_q     <= WREADY;
      arv_q    <= ARVALID;
      arr_q    <= ARREADY;
      awaddr_q <= AWADDR;
      awlen_q  <= AWLEN;
    end
  end

  // Write burst tracking
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LEN_WIDTH-1:0] fifo_head, len_cur, beat;
  logic                 have_len, w_end, w_match, w_done, bypass;

  amba_axi4_len_fifo #(.WIDTH(LEN_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_len_fifo (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .push   (fifo_push),
    .din    (AWLEN),
    .pop    (fifo_pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  // An empty FIFO lets a same-cycle AW feed its length straight to the W beat.
  assign len_cur  = fifo_empty ? AWLEN : fifo_head;
  assign have_len = ~fifo_empty | aw_hs;
  assign w_end    = (beat == len_cur);
  assign w_match  = w_hs & have_len;
  assign w_done   = w_match & (WLAST | w_end);
  assign fifo_pop = w_done & ~fifo_empty;
  assign bypass   = w_done & fifo_empty;
  assign fifo_push = aw_hs & ~bypass;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)       beat <= '0;
    else if (w_done)  beat <= '0;
    else if (w_match) beat <= beat + LEN_WIDTH'(1);
  end

  // Outstanding burst counters
  logic wr_inc, wr_dec, rd_inc, rd_dec;
  assign wr_inc = w_done;
  assign wr_dec = b_hs & (wr_outstanding != '0);
  assign rd_inc = ar_hs;
  assign rd_dec = r_hs & RLAST & (rd_outstanding != '0);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_outstanding <= '0;
      rd_outstanding <= '0;
    end else begin
      case ({wr_inc, wr_dec})
        2'b10:   if (wr_outstanding != MAX_OUT) wr_outstanding <= wr_outstanding + CW'(1);
        2'b01:   wr_outstanding <= wr_outstanding - CW'(1);
        default: wr_outstanding <= wr_outstanding;
      endcase
      case ({rd_inc, rd_dec})
        2'b10:   if (rd_outstanding != MAX_OUT) rd_outstanding <= rd_outstanding + CW'(1);
        2'b01:   rd_outstanding <= rd_outstanding - CW'(1);
        default: rd_outstanding <= rd_outstanding;
      endcase
    end
  end

  // Stall timeouts, channel order AW, W, B, AR, R
  logic [NUM_CH-1:0] ch_valid, ch_ready, stall_hit;
  assign ch_valid = {RVALID, ARVALID, BVALID, WVALID, AWVALID};
  assign ch_ready = {RREADY, ARREADY, BREADY, WREADY, AWREADY};

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_stall
      logic [SW-1:0] cnt;
      logic          stalled;
      assign stalled = ch_valid[g] & ~ch_ready[g];
      // Saturating at MAXWAIT keeps the timeout to one report per episode.
      assign stall_hit[g] = stalled & (cnt == MAXW - SW'(1));
      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)         cnt <= '0;
        else if (!stalled)  cnt <= '0;
        else if (cnt != MAXW) cnt <= cnt + SW'(1);
      end
    end
  endgenerate

  // Violation vector, bit i-1 for code i
  logic [ERR_COUNT-1:0] errs;

  always_comb begin
    errs     = '0;
    errs[0]  = awv_q & ~awr_q & ~AWVALID;
    errs[1]  = awv_q & ~awr_q & AWVALID & ((AWADDR != awaddr_q) | (AWLEN != awlen_q));
    errs[2]  = wv_q & ~wr_q & ~WVALID;
    errs[3]  = w_hs & ~have_len;
    errs[4]  = w_match & WLAST & ~w_end;
    errs[5]  = w_match & w_end & ~WLAST;
    errs[6]  = b_hs & (wr_outstanding == '0);
    errs[7]  = arv_q & ~arr_q & ~ARVALID;
    errs[8]  = r_hs & (rd_outstanding == '0);
    errs[9]  = (fifo_push & fifo_full & ~fifo_pop) |
               (ar_hs & ~rd_dec & (rd_outstanding == MAX_OUT));
    errs[10] = |stall_hit;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_valid  <= 1'b0;
      err_code   <= 4'd0;
      err_sticky <= '0;
    end else begin
      err_valid  <= |errs;
      err_code   <= first_err(errs);
      err_sticky <= err_sticky | errs;
    end
  end

endmodule

// File: tb/tb_amba_axi4_burst_monitor.sv
// Table-driven bench for the AXI4 burst monitor with an expected-result queue.
module tb_amba_axi4_burst_monitor;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [31:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic        err_valid;
  logic [3:0]  err_code;
  logic [10:0] err_sticky;
  logic [3:0]  wr_outstanding, rd_outstanding;

  amba_axi4_burst_monitor #(.ADDRESS_WIDTH(32), .MAX_OUTSTANDING(8), .MAXWAIT(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
    .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
  );

  always #5 ACLK = ~ACLK;

  // ctl bits: {awv,awr, wv,wr,wl, bv,br, arv,arr, rv,rr,rl}
  localparam logic [11:0] IDLE = 12'b00_000_00_00_000;
  localparam logic [11:0] AW   = 12'b11_000_00_00_000;
  localparam logic [11:0] AWS  = 12'b10_000_00_00_000;
  localparam logic [11:0] W    = 12'b00_110_00_00_000;
  localparam logic [11:0] WL   = 12'b00_111_00_00_000;
  localparam logic [11:0] WS   = 12'b00_100_00_00_000;
  localparam logic [11:0] B    = 12'b00_000_11_00_000;
  localparam logic [11:0] AR   = 12'b00_000_00_11_000;
  localparam logic [11:0] ARS  = 12'b00_000_00_10_000;
  localparam logic [11:0] R    = 12'b00_000_00_00_110;
  localparam logic [11:0] RL   = 12'b00_000_00_00_111;

  typedef struct {
    logic [11:0] ctl;
    logic [7:0]  len;
    logic [31:0] addr;
    logic [3:0]  code;
    logic [3:0]  wr;
    logic [3:0]  rd;
  } vec_t;

  vec_t        tbl[$];
  vec_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [10:0] exp_sticky = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [11:0] ctl, input logic [7:0] len, input logic [31:0] addr,
                     input logic [3:0] code, input logic [3:0] wr, input logic [3:0] rd);
    vec_t v;
    v.ctl = ctl; v.len = len; v.addr = addr; v.code = code; v.wr = wr; v.rd = rd;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    {AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY,
     ARVALID, ARREADY, RVALID, RREADY, RLAST} = v.ctl;
    AWLEN = v.len; ARLEN = v.len; AWADDR = v.addr; ARADDR = v.addr;
  endtask

  // Drive one cycle, queue its expectation, compare once the DUT registers it.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge ACLK);
    apply(v);
    exp_q.push_back(v);
    @(posedge ACLK);
    #1;
    e = exp_q.pop_front();
    if (e.code != 4'd0) exp_sticky = exp_sticky | (11'd1 << (e.code - 4'd1));
    chk({tag, " err_code"},   {28'd0, err_code}, {28'd0, e.code});
    chk({tag, " err_valid"},  {31'd0, err_valid}, {31'd0, e.code != 4'd0});
    chk({tag, " err_sticky"}, {21'd0, err_sticky}, {21'd0, exp_sticky});
    chk({tag, " wr_out"},     {28'd0, wr_outstanding}, {28'd0, e.wr});
    chk({tag, " rd_out"},     {28'd0, rd_outstanding}, {28'd0, e.rd});
  endtask

  task automatic run_tbl(input string tag);
    foreach (tbl[i]) step(tbl[i], $sformatf("%s[%0d]", tag, i));
    tbl.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " err_valid"},  {31'd0, err_valid}, 32'd0);
    chk({tag, " err_code"},   {28'd0, err_code}, 32'd0);
    chk({tag, " err_sticky"}, {21'd0, err_sticky}, 32'd0);
    chk({tag, " wr_out"},     {28'd0, wr_outstanding}, 32'd0);
    chk({tag, " rd_out"},     {28'd0, rd_outstanding}, 32'd0);
  endtask

  initial begin
    vec_t idle_v;
    idle_v.ctl = IDLE; idle_v.len = '0; idle_v.addr = '0;
    idle_v.code = '0; idle_v.wr = '0; idle_v.rd = '0;
    ARESET = 1'b1;
    apply(idle_v);
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk_zero("reset");
    ARESET = 1'b0;

    // Burst length, outstanding and response checks
    add(AW, 8'd3, 32'h100, 0, 0, 0);
    add(W,  8'd3, 32'h100, 0, 0, 0);
    add(W,  8'd3, 32'h100, 0, 0, 0);
    add(W,  8'd3, 32'h100, 0, 0, 0);
    add(WL, 8'd3, 32'h100, 0, 1, 0);
    add(B,  8'd0, 32'h0,   0, 0, 0);
    add(AW, 8'd3, 32'h200, 0, 0, 0);
    add(W,  8'd0, 32'h0,   0, 0, 0);
    add(W,  8'd0, 32'h0,   0, 0, 0);
    add(WL, 8'd0, 32'h0,   5, 1, 0);
    add(B,  8'd0, 32'h0,   0, 0, 0);
    add(WL, 8'd0, 32'h0,   4, 0, 0);
    add(AW | WL, 8'd0, 32'h300, 0, 1, 0);
    add(B,  8'd0, 32'h0,   0, 0, 0);
    add(AW, 8'd0, 32'h400, 0, 0, 0);
    add(W,  8'd0, 32'h0,   6, 1, 0);
    add(B,  8'd0, 32'h0,   0, 0, 0);
    add(AR, 8'd2, 32'h500, 0, 0, 1);
    add(R,  8'd0, 32'h0,   0, 0, 1);
    add(RL, 8'd0, 32'h0,   0, 0, 0);
    add(RL, 8'd0, 32'h0,   9, 0, 0);
    add(B,  8'd0, 32'h0,   7, 0, 0);
    add(AR, 8'd0, 32'h600, 0, 0, 1);
    add(AR | RL, 8'd0, 32'h700, 0, 0, 1);
    add(RL, 8'd0, 32'h0,   0, 0, 0);
    add(AWS, 8'd0, 32'h800, 0, 0, 0);
    add(IDLE, 8'd0, 32'h0, 1, 0, 0);
    add(WS, 8'd0, 32'h0,   0, 0, 0);
    add(IDLE, 8'd0, 32'h0, 3, 0, 0);
    add(ARS, 8'd0, 32'h900, 0, 0, 0);
    add(IDLE, 8'd0, 32'h0, 8, 0, 0);
    run_tbl("tbl");

    // AW stall: timeout on the 16th stalled cycle only, then payload change
    for (int i = 1; i <= 18; i++)
      add(AWS, 8'd0, 32'h1000, (i == 16) ? 4'd11 : 4'd0, 0, 0);
    add(AWS, 8'd0, 32'h2000, 2, 0, 0);
    add(AW,  8'd0, 32'h2000, 0, 0, 0);
    add(WL,  8'd0, 32'h0,    0, 1, 0);
    add(B,   8'd0, 32'h0,    0, 0, 0);
    run_tbl("stall");

    // Length FIFO overflow on the 9th unanswered AW
    for (int i = 1; i <= 9; i++)
      add(AW, 8'd0, 32'h3000 + 32'(i), (i == 9) ? 4'd10 : 4'd0, 0, 0);
    add(AW, 8'd1, 32'h4000, 10, 0, 0);
    run_tbl("ovf");

    // Reset mid-burst wipes everything at once
    @(negedge ACLK);
    apply(tbl.size() == 0 ? idle_v : idle_v);
    WVALID = 1'b1; WREADY = 1'b1; WLAST = 1'b0;
    #1;
    chk("pre-reset sticky nonzero", {31'd0, err_sticky != 11'd0}, 32'd1);
    #1;
    ARESET = 1'b1;
    #1;
    chk_zero("async reset");
    apply(idle_v);
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk_zero("held reset");
    ARESET = 1'b0;
    exp_sticky = '0;

    add(AW, 8'd1, 32'h5000, 0, 0, 0);
    add(W,  8'd0, 32'h0,    0, 0, 0);
    add(WL, 8'd0, 32'h0,    0, 1, 0);
    add(B,  8'd0, 32'h0,    0, 0, 0);
    run_tbl("fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/amba_axi4_burst_monitor.md
# amba_axi4_burst_monitor

Synthesizable AXI4 full-protocol monitor. It extends our AXI4 interface checks from single-beat handshakes to bursts. It tracks AWLEN/ARLEN, counts W beats against WLAST, and counts outstanding write and read bursts. It also checks VALID/payload stability and stall timeouts. It sits passively on one manager/subordinate link and reports violations as registered error outputs for simulation scoreboards and on-chip debug.

## Interface
- ADDRESS_WIDTH, 32, AWADDR/ARADDR width
- MAX_OUTSTANDING, 8, AW FIFO depth and outstanding-counter limit (power of 2, ≥2)
- MAXWAIT, 16, max cycles VALID may stay high without READY
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  reset, asynchronous, active-high
- AWVALID, AWREADY  in  1 each; AWADDR  in  ADDRESS_WIDTH; AWLEN  in  8
- WVALID, WREADY, WLAST  in  1 each
- BVALID, BREADY  in  1 each
- ARVALID, ARREADY  in  1 each; ARADDR  in  ADDRESS_WIDTH; ARLEN  in  8
- RVALID, RREADY, RLAST  in  1 each
- err_valid  out  1  one-cycle pulse, ≥1 violation detected last cycle
- err_code  out  4  lowest-numbered violation of that cycle
- err_sticky  out  11  bit i-1 set forever (until reset) by code i
- wr_outstanding  out  $clog2(MAX_OUTSTANDING+1)  bursts awaiting B
- rd_outstanding  out  $clog2(MAX_OUTSTANDING+1)  bursts awaiting final R

## Operation
- Handshake = VALID & READY at a rising edge.
- AW handshake pushes AWLEN into the len FIFO. A push when the FIFO is full and not popping flags code 10 (OVERFLOW) and drops the entry.
- W beat counter starts at 0 and compares with the FIFO head:
  - If beat < len and WLAST is high → code 5 (WLAST_EARLY); treat the beat as last.
  - If beat == len and WLAST is low → code 6 (WLAST_MISSING); treat the beat as last.
  - A last beat pops the FIFO, clears the counter and increments wr_outstanding.
- W handshake with FIFO empty and no same-cycle AW handshake → code 4 (W_NO_AW). Early write data is not supported. The beat is otherwise ignored.
- Same-cycle AW + W on an empty FIFO: the W beat is matched against the incoming AWLEN (bypass).
- B handshake decrements wr_outstanding. If it is 0 → code 7 (B_UNEXPECTED), no decrement.
- AR handshake increments rd_outstanding. At MAX_OUTSTANDING → code 10, saturate.
- R handshake with RLAST decrements rd_outstanding. R handshake with rd_outstanding 0 → code 9 (R_UNEXPECTED). Per-ID RLAST beat counts are out of scope.
- Stability checks:
  - AWVALID falling without AWREADY → code 1.
  - AWADDR/AWLEN changing while AWVALID & !AWREADY was registered last cycle → code 2.
  - WVALID drop → code 3.
  - ARVALID drop → code 8.
- Timeout: a per-channel (AW, W, B, AR, R) stall counter increments while VALID & !READY and clears otherwise. Reaching MAXWAIT → code 11, once per stall episode.
- Simultaneous inc/dec on one outstanding counter leaves it unchanged.

## Timing
- ARESET asserted: all outputs 0 (err_valid, err_code, err_sticky, both counters), FIFO empty, beat and stall counters 0, prior-VALID registers 0.
- Reset mid-burst discards all state. No error is flagged for the interrupted burst.
- Errors are detected from cycle-N inputs. err_valid, err_code and the sticky update appear registered at cycle N+1.
- Counters reflect handshakes of cycle N at cycle N+1.
- Beat counter is 8 bits. AWLEN=255 gives 256 beats with no wrap error.

## Structure
- Package amba_axi4_monitor_pkg:
  - err_code_t enum with NONE=0 plus codes 1–11 above.
  - localparams ERR_COUNT=11 and LEN_WIDTH=8.
- Sub-module amba_axi4_len_fifo: synchronous FIFO, parameters WIDTH and DEPTH, with push/pop/full/empty/head. It supports simultaneous push and pop when full.
- Stall counters are one generate loop over 5 channels.

## Test plan
- AW AWLEN=3, then 4 W beats with WLAST on the 4th → no error, wr_outstanding=1; then B → 0.
- AWLEN=3, WLAST on beat 2 → err_code=5 at next cycle, err_sticky[4]=1, wr_outstanding=1.
- W handshake with no AW; separately, same-cycle AW(AWLEN=0)+W(WLAST=1) on empty FIFO → code 4 for the first only, bypass case clean.
- 9 AWs with MAX_OUTSTANDING=8 and no W → code 10 on the 9th; BVALID&BREADY with wr_outstanding=0 → code 7.
- AWVALID held with AWREADY low for 16 cycles → code 11 once. AWADDR changed mid-stall → code 2. ARVALID dropped unaccepted → code 8.
- ARESET asserted mid-burst with err_sticky≠0 → all outputs 0 immediately. A fresh burst after release runs clean.
